kdsp_channel_pipe: RTL and testbench

//  Parametrised streaming per-channel arithmetic stage for the Kdsp datapath: supersedes the fixed b/g/r

---
 rtl/kdsp_channel_pipe.sv | 153 +++++++++++++++
 tb/tb_kdsp_channel_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kdsp_channel_pipe.sv
// Two-stage streaming per-channel arithmetic (ADD/SUB/MUL/PASS) with programmable coefficients.
// Build option: define KDSP_SAT_EN to clamp overflow/underflow and report it on out_sat.
module kdsp_channel_pipe #(
    parameter  int unsigned DATA_W   = 8,
    parameter  int unsigned COEF_W   = 8,
    parameter  int unsigned NUM_CH   = 3,
    parameter  int unsigned FRAC_W   = 4,
    parameter  int unsigned COEF_RST = 16,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [COEF_W-1:0] cfg_coef,
    input  logic              mode_we,
    input  logic [1:0]        mode_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic              out_sat
);

    localparam int unsigned IW = DATA_W + COEF_W + 1;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_MUL  = 2'd2,
        MODE_PASS = 2'd3
    } mode_t;

    logic              en;
    logic              accept;
    logic [CH_W-1:0]   cnt_q;
    logic [CH_W-1:0]   ch_c;
    logic [COEF_W-1:0] coef_q [NUM_CH];
    mode_t             mode_q;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [COEF_W-1:0] s1_coef;
    mode_t             s1_mode;
    logic [CH_W-1:0]   s1_ch;

    logic [IW-1:0]     res_c;
    logic [DATA_W-1:0] data_c;
`ifdef KDSP_SAT_EN
    logic              sat_c;
`endif

    // Whole pipe advances together; stalls only when a result is waiting downstream
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;
    assign ch_c     = in_sof ? '0 : cnt_q;

    // Coefficient and mode registers; an accepted sample reads the pre-write value
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                coef_q[i] <= COEF_W'(COEF_RST);
            end
            mode_q <= MODE_PASS;
        end else begin
            if (cfg_we && (32'(cfg_ch) < NUM_CH)) begin
                coef_q[cfg_ch] <= cfg_coef;
            end
            if (mode_we) begin
                mode_q <= mode_t'(mode_in);
            end
        end
    end

    // Channel counter and stage 1 capture
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_coef  <= '0;
            s1_mode  <= MODE_PASS;
            s1_ch    <= '0;
        end else begin
            if (accept) begin
                cnt_q <= (ch_c == CH_W'(NUM_CH - 1)) ? '0 : ch_c + CH_W'(1);
            end
            if (en) begin
                s1_valid <= in_valid;
                s1_data  <= in_data;
                s1_coef  <= coef_q[ch_c];
                s1_mode  <= mode_q;
                s1_ch    <= ch_c;
            end
        end
    end

    // Stage 2 arithmetic at full internal width
    always_comb begin
        res_c = '0;
        case (s1_mode)
            MODE_ADD: res_c = IW'(s1_data) + IW'(s1_coef);
            MODE_SUB: res_c = IW'(s1_data) - IW'(s1_coef);
            MODE_MUL: res_c = (IW'(s1_data) * IW'(s1_coef)) >> FRAC_W;
            default:  res_c = IW'(s1_data);
        endcase
        data_c = DATA_W'(res_c);
`ifdef KDSP_SAT_EN
        sat_c = 1'b0;
        if ((s1_mode == MODE_SUB) && (IW'(s1_data) < IW'(s1_coef))) begin
            data_c = '0;
            sat_c  = 1'b1;
        end else if (|res_c[IW-1:DATA_W]) begin
            data_c = '1;
            sat_c  = 1'b1;
        end
`endif
    end

    // Stage 2 output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
`ifdef KDSP_SAT_EN
            out_sat   <= 1'b0;
`endif
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_c;
                out_ch   <= s1_ch;
                out_last <= (s1_ch == CH_W'(NUM_CH - 1));
`ifdef KDSP_SAT_EN
                out_sat  <= sat_c;
`endif
            end
        end
    end

`ifndef KDSP_SAT_EN
    assign out_sat = 1'b0;
`endif

endmodule

// File: tb/tb_kdsp_channel_pipe.sv
// Randomised scoreboard bench for kdsp_channel_pipe against an arithmetic reference model.
module tb_kdsp_channel_pipe;

    localparam int DATA_W   = 8;
    localparam int COEF_W   = 8;
    localparam int NUM_CH   = 3;
    localparam int CH_W     = 2;
    localparam int FRAC_W   = 4;
    localparam int COEF_RST = 16;
    localparam int DMAX     = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_sof;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [COEF_W-1:0] cfg_coef;
    logic              mode_we;
    logic [1:0]        mode_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_last;
    logic              out_sat;

    kdsp_channel_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_coef(cfg_coef),
        .mode_we(mode_we), .mode_in(mode_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int ch;
        int last;
        int sat;
        int acc_cyc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    int   m_coef [NUM_CH];
    int   m_mode;
    int   m_cnt;
    bit   head_shown;
    bit   prev_stall;
    int   prev_data;
    bit   lat_chk = 1'b0;
    int   rdy_mode = 0;
    int   stall_end = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference arithmetic on plain integers
    function automatic void ref_calc(input int d, input int c, input int md,
                                     output int r, output int s);
        case (md)
            0:       r = d + c;
            1:       r = d - c;
            2:       r = (d * c) / (1 << FRAC_W);
            default: r = d;
        endcase
        s = 0;
`ifdef KDSP_SAT_EN
        if (r > DMAX) begin
            r = DMAX;
            s = 1;
        end else if (r < 0) begin
            r = 0;
            s = 1;
        end
`else
        r = r & DMAX;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: 0 always-ready, 1 random, 2 held low; plus a timed stall window
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (cyc < stall_end)    out_ready = 1'b0;
            else if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (rdy_mode == 2) out_ready = 1'b0;
            else                    out_ready = 1'b1;
        end
    end

    // Monitor/model: observes the cycle ahead of each rising edge
    always @(negedge clk) begin
        exp_t e;
        int   r;
        int   s;
        int   ch;
        if (reset) begin
            sb.delete();
            m_cnt      = 0;
            m_mode     = 3;
            head_shown = 1'b0;
            prev_stall = 1'b0;
            for (int i = 0; i < NUM_CH; i++) m_coef[i] = COEF_RST;
        end else begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_data", 32'(out_data), prev_data);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 0);
                end else begin
                    if (!head_shown) begin
                        head_shown = 1'b1;
                        if (lat_chk) check("latency", cyc - sb[0].acc_cyc, 2);
                    end
                    if (out_ready) begin
                        e = sb.pop_front();
                        check("out_data", 32'(out_data), e.data);
                        check("out_ch", 32'(out_ch), e.ch);
                        check("out_last", 32'(out_last), e.last);
                        check("out_sat", 32'(out_sat), e.sat);
                        head_shown = 1'b0;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = int'(out_data);
            if (in_valid && in_ready) begin
                ch = in_sof ? 0 : m_cnt;
                ref_calc(int'(in_data), m_coef[ch], m_mode, r, s);
                e.data    = r;
                e.ch      = ch;
                e.last    = (ch == NUM_CH - 1) ? 1 : 0;
                e.sat     = s;
                e.acc_cyc = cyc;
                sb.push_back(e);
                m_cnt = (ch + 1) % NUM_CH;
            end
            if (cfg_we && int'(cfg_ch) < NUM_CH) m_coef[cfg_ch] = int'(cfg_coef);
            if (mode_we) m_mode = int'(mode_in);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input bit sof, input bit cwe = 1'b0, input int cch = 0,
                        input int ccoef = 0, input bit mwe = 1'b0, input int mval = 0);
        bit ok = 1'b0;
        int n  = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(d);
        in_sof   = sof;
        cfg_we   = cwe;
        cfg_ch   = CH_W'(cch);
        cfg_coef = COEF_W'(ccoef);
        mode_we  = mwe;
        mode_in  = 2'(mval);
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end
        check("send_accepted", 32'(ok), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        cfg_we   = 1'b0;
        mode_we  = 1'b0;
    endtask

    task automatic cfg(input int ch, input int c);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_coef = COEF_W'(c);
        idle(1);
        cfg_we = 1'b0;
    endtask

    task automatic set_mode(input int m);
        mode_we = 1'b1;
        mode_in = 2'(m);
        idle(1);
        mode_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            idle(1);
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sof   = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_coef = '0;
        mode_we  = 1'b0;
        mode_in  = '0;
        idle(2);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_ch", 32'(out_ch), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_out_sat", 32'(out_sat), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // PASS stream with exact latency
        lat_chk = 1'b1;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        idle(4);

        // MUL with per-channel gains
        cfg(0, 8'h10);
        cfg(1, 8'h20);
        cfg(2, 8'h08);
        set_mode(2);
        send(8'h40, 1'b0);
        send(8'h40, 1'b0);
        send(8'h40, 1'b0);
        idle(4);

        // ADD overflow and SUB underflow boundaries
        cfg(0, 8'hF0);
        set_mode(0);
        send(8'h20, 1'b1);
        cfg(0, 8'h30);
        set_mode(1);
        send(8'h10, 1'b1);
        idle(4);

        // Frame restart mid-triple and same-cycle coefficient write
        set_mode(0);
        cfg(1, 8'h01);
        send(8'h10, 1'b1);
        send(8'h11, 1'b1);
        send(8'h12, 1'b0, 1'b1, 1, 8'h05);
        send(8'h13, 1'b0);
        send(8'h14, 1'b0);
        send(8'h15, 1'b0);
        idle(4);
        lat_chk = 1'b0;

        // Random traffic under random backpressure with one fixed 5-cycle stall
        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            bit cwe;
            bit mwe;
            if ($urandom_range(0, 3) == 0) idle(1);
            if (i == 50) stall_end = cyc + 6;
            cwe = ($urandom_range(0, 4) == 0);
            mwe = !cwe && ($urandom_range(0, 7) == 0);
            send($urandom_range(0, DMAX), ($urandom_range(0, 9) == 0), cwe,
                 cwe ? $urandom_range(0, (1 << CH_W) - 1) : 0,
                 $urandom_range(0, (1 << COEF_W) - 1), mwe, $urandom_range(0, 3));
        end
        rdy_mode = 0;
        drain();

        // Reset with both stages full
        rdy_mode = 2;
        idle(1);
        send(8'h21, 1'b0);
        send(8'h22, 1'b0);
        @(negedge clk);
        check("full_before_rst", 32'(out_valid), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 0);
        check("rst_mid_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        send(8'h05, 1'b0);
        set_mode(2);
        send(8'h40, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
